// File: rtl/uart_tx_fifo_if.sv
// Bus-side signal bundle for uart_tx_fifo: CPU write path, overflow clear and status/serial outputs.
// master = bus decoder / CPU side, slave = UART peripheral.
interface uart_tx_fifo_if #(
  parameter int FIFO_AW = 3
);
  logic               we;
  logic [7:0]         wdata;
  logic               clr_ovf;
  logic               txd;
  logic               tx_busy;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_AW:0]   level;
  logic [31:0]        status;

  modport master (
    output we, wdata, clr_ovf,
    input  txd, tx_busy, fifo_full, fifo_empty, level, status
  );

  modport slave (
    input  we, wdata, clr_ovf,
    output txd, tx_busy, fifo_full, fifo_empty, level, status
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter: 2**FIFO_AW byte FIFO feeding a baud-timed 8N1 serialiser.
// Optional even-parity bit (8E1) enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int BAUD_DIV = 868,
  parameter int FIFO_AW  = 3
) (
  input  logic             clk,
  input  logic             RSTN,
  uart_tx_fifo_if.slave    bus
);

  localparam int                DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]  LVL_FULL  = DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0]  LVL_ONE   = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [15:0]       BAUD_LAST = 16'(BAUD_DIV - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic              PAR_EN    = 1'b1;
`else
  localparam logic              PAR_EN    = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_level;
  logic               r_full;
  logic               r_empty;
  logic               r_ovf;
  logic               r_txd;
  state_t             r_state;
  logic [15:0]        r_baud_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
`ifdef UART_TX_PARITY_EN
  logic               r_par;
`endif

  state_t             w_state_nxt;
  logic [FIFO_AW:0]   w_level_nxt;
  logic [7:0]         w_shift_nxt;
  logic [7:0]         w_head;
  logic               w_txd_nxt;
  logic               w_baud_end;
  logic               w_pop;
  logic               w_push;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_baud_end = (r_baud_cnt == BAUD_LAST);
  // A full FIFO still accepts a byte when the serialiser pops in the same cycle.
  assign w_push     = bus.we && (!r_full || w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_baud_end && r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_end) w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_baud_end) begin
          if (!r_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + LVL_ONE;
    else if (w_pop && !w_push) w_level_nxt = r_level - LVL_ONE;
  end

  always_comb begin
    w_shift_nxt = r_shift;
    if (w_pop)                                  w_shift_nxt = w_head;
    else if (r_state == S_DATA && w_baud_end)   w_shift_nxt = {1'b0, r_shift[7:1]};
  end

  // txd is registered from the upcoming state so the pin never glitches.
  always_comb begin
    w_txd_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_txd_nxt = r_par;
`endif
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_ovf      <= 1'b0;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_FULL);
      r_empty <= (w_level_nxt == '0);
      // A rejected push wins over a same-cycle clear.
      if (bus.we && !w_push) r_ovf <= 1'b1;
      else if (bus.clr_ovf)  r_ovf <= 1'b0;
      if (r_state == S_IDLE || w_baud_end) r_baud_cnt <= '0;
      else                                 r_baud_cnt <= r_baud_cnt + 16'd1;
      if (r_state == S_START)                   r_bit_idx <= '0;
      else if (r_state == S_DATA && w_baud_end) r_bit_idx <= r_bit_idx + 3'd1;
      r_txd <= w_txd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.wdata;
    r_shift <= w_shift_nxt;
`ifdef UART_TX_PARITY_EN
    if (w_pop) r_par <= ^w_head;
`endif
  end

  assign bus.txd        = r_txd;
  assign bus.tx_busy    = (r_state != S_IDLE);
  assign bus.fifo_full  = r_full;
  assign bus.fifo_empty = r_empty;
  assign bus.level      = r_level;
  assign bus.status     = {22'b0, PAR_EN, 1'b0, r_ovf, 4'(r_level),
                           (r_state != S_IDLE), r_full, r_empty};

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with BAUD_DIV=4 and an 8-deep FIFO.
module tb_uart_tx_fifo;

  localparam int B  = 4;
  localparam int AW = 3;
`ifdef UART_TX_PARITY_EN
  localparam int          P      = 1;
  localparam logic [31:0] ST_RST = 32'h0000_0201;
`else
  localparam int          P      = 0;
  localparam logic [31:0] ST_RST = 32'h0000_0001;
`endif
  localparam int FR = (10 + P) * B;

  logic clk  = 1'b0;
  logic RSTN = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_tx_fifo_if #(.FIFO_AW(AW)) bus ();

  uart_tx_fifo #(.BAUD_DIV(B), .FIFO_AW(AW)) dut (
    .clk  (clk),
    .RSTN (RSTN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Expected txd on the kk-th cycle (1-based) of a frame carrying byte b.
  function automatic logic exp_txd(input logic [7:0] b, input int kk);
    if (kk <= B)                return 1'b0;
    if (kk <= 9 * B)            return b[(kk - B - 1) / B];
    if (P == 1 && kk <= 10 * B) return ^b;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] b);
    bus.we    = 1'b1;
    bus.wdata = b;
    tick();
    bus.we    = 1'b0;
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.we    = (i == 0);
      bus.wdata = 8'hC3;
      tick();
    end
    bus.we = 1'b0;
    RSTN   = 1'b1;
    n_checks++; if (bus.txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %0h expected 1", bus.txd); end
    n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
    n_checks++; if (bus.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0h expected 1", bus.fifo_empty); end
    n_checks++; if (bus.tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h expected 0", bus.tx_busy); end
    n_checks++; if (bus.status !== ST_RST) begin n_fail++; $display("FAIL reset_status: got %08h expected %08h", bus.status, ST_RST); end
    tick();
    n_checks++; if (bus.level !== 4'd0 || bus.tx_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_push: got level=%0d busy=%0h expected level=0 busy=0", bus.level, bus.tx_busy);
    end
  endtask

  task automatic test_single();
    do_write(8'hA5);
    n_checks++; if (bus.level !== 4'd1 || bus.fifo_empty !== 1'b0) begin
      n_fail++; $display("FAIL single_push: got level=%0d empty=%0h expected level=1 empty=0", bus.level, bus.fifo_empty);
    end
    for (int k = 1; k <= FR; k++) begin
      tick();
      n_checks++; if (bus.txd !== exp_txd(8'hA5, k)) begin
        n_fail++; $display("FAIL single_txd cyc %0d: got %0h expected %0h", k, bus.txd, exp_txd(8'hA5, k));
      end
      n_checks++; if (bus.tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy cyc %0d: got 0 expected 1", k); end
      if (k == 1) begin
        n_checks++; if (bus.level !== 4'd0) begin n_fail++; $display("FAIL single_pop_level: got %0d expected 0", bus.level); end
      end
    end
    tick();
    n_checks++; if (bus.tx_busy !== 1'b0 || bus.txd !== 1'b1 || bus.fifo_empty !== 1'b1) begin
      n_fail++; $display("FAIL single_end: got busy=%0h txd=%0h empty=%0h expected 0,1,1", bus.tx_busy, bus.txd, bus.fifo_empty);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] eb;
    do_write(8'h55);
    n_checks++; if (bus.level !== 4'd1) begin n_fail++; $display("FAIL b2b_level_a: got %0d expected 1", bus.level); end
    do_write(8'h0F);
    n_checks++; if (bus.level !== 4'd1) begin n_fail++; $display("FAIL b2b_level_b: got %0d expected 1", bus.level); end
    n_checks++; if (bus.txd !== 1'b0) begin n_fail++; $display("FAIL b2b_first_start: got %0h expected 0", bus.txd); end
    for (int k = 2; k <= 2 * FR; k++) begin
      tick();
      eb = ((k - 1) / FR == 0) ? 8'h55 : 8'h0F;
      n_checks++; if (bus.txd !== exp_txd(eb, (k - 1) % FR + 1)) begin
        n_fail++; $display("FAIL b2b_txd cyc %0d: got %0h expected %0h", k, bus.txd, exp_txd(eb, (k - 1) % FR + 1));
      end
      if (k == FR + 1) begin
        n_checks++; if (bus.level !== 4'd0 || bus.tx_busy !== 1'b1) begin
          n_fail++; $display("FAIL b2b_second_pop: got level=%0d busy=%0h expected 0,1", bus.level, bus.tx_busy);
        end
      end
    end
    tick();
    n_checks++; if (bus.tx_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end_busy: got 1 expected 0"); end
  endtask

  task automatic test_overflow();
    logic [7:0] eb;
    int f;
    for (int k = 0; k <= 10 * FR; k++) begin
      bus.we      = (k <= 11) || (k == FR + 1);
      bus.wdata   = (k == 0) ? 8'hFF : (k <= 10) ? 8'(k - 1) : (k == 11) ? 8'hEE : 8'hAA;
      bus.clr_ovf = (k == 11) || (k == 12);
      tick();
      if (k >= 1) begin
        f  = (k - 1) / FR;
        eb = (f == 0) ? 8'hFF : (f <= 8) ? 8'(f - 1) : 8'hAA;
        n_checks++; if (bus.txd !== exp_txd(eb, (k - 1) % FR + 1)) begin
          n_fail++; $display("FAIL ovf_txd cyc %0d: got %0h expected %0h", k, bus.txd, exp_txd(eb, (k - 1) % FR + 1));
        end
      end
      if (k == 8) begin
        n_checks++; if (bus.level !== 4'd8 || bus.fifo_full !== 1'b1 || bus.status[7] !== 1'b0) begin
          n_fail++; $display("FAIL ovf_fill: got level=%0d full=%0h ovf=%0h expected 8,1,0", bus.level, bus.fifo_full, bus.status[7]);
        end
      end
      if (k == 9 || k == 10) begin
        n_checks++; if (bus.level !== 4'd8 || bus.status[7] !== 1'b1) begin
          n_fail++; $display("FAIL ovf_set cyc %0d: got level=%0d ovf=%0h expected 8,1", k, bus.level, bus.status[7]);
        end
      end
      if (k == 11) begin
        n_checks++; if (bus.status[7] !== 1'b1) begin n_fail++; $display("FAIL ovf_clr_vs_reject: got 0 expected 1"); end
      end
      if (k == 12) begin
        n_checks++; if (bus.status[7] !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got 1 expected 0"); end
      end
      if (k == FR + 1) begin
        n_checks++; if (bus.level !== 4'd8 || bus.fifo_full !== 1'b1 || bus.status[7] !== 1'b0) begin
          n_fail++; $display("FAIL full_push_pop: got level=%0d full=%0h ovf=%0h expected 8,1,0", bus.level, bus.fifo_full, bus.status[7]);
        end
      end
      if (k == 2 * FR + 1) begin
        n_checks++; if (bus.level !== 4'd7) begin n_fail++; $display("FAIL ovf_drain: got %0d expected 7", bus.level); end
      end
    end
    bus.we = 1'b0; bus.clr_ovf = 1'b0;
    tick();
    n_checks++; if (bus.tx_busy !== 1'b0 || bus.fifo_empty !== 1'b1) begin
      n_fail++; $display("FAIL ovf_end: got busy=%0h empty=%0h expected 0,1", bus.tx_busy, bus.fifo_empty);
    end
  endtask

  task automatic test_reset_midframe();
    do_write(8'h3C);
    do_write(8'h3D);
    for (int k = 0; k < 10; k++) tick();
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
    n_checks++; if (bus.txd !== 1'b1 || bus.tx_busy !== 1'b0 || bus.level !== 4'd0 || bus.fifo_empty !== 1'b1) begin
      n_fail++; $display("FAIL midframe_reset: got txd=%0h busy=%0h level=%0d empty=%0h expected 1,0,0,1",
                         bus.txd, bus.tx_busy, bus.level, bus.fifo_empty);
    end
    for (int k = 0; k < 3; k++) tick();
    n_checks++; if (bus.txd !== 1'b1 || bus.tx_busy !== 1'b0) begin
      n_fail++; $display("FAIL midframe_idle: got txd=%0h busy=%0h expected 1,0", bus.txd, bus.tx_busy);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] eb;
    do_write(8'h07);
    do_write(8'h03);
    n_checks++; if (bus.status[9] !== 1'b1) begin n_fail++; $display("FAIL parity_status: got 0 expected 1"); end
    for (int k = 2; k <= 2 * FR; k++) begin
      tick();
      eb = ((k - 1) / FR == 0) ? 8'h07 : 8'h03;
      n_checks++; if (bus.txd !== exp_txd(eb, (k - 1) % FR + 1)) begin
        n_fail++; $display("FAIL parity_txd cyc %0d: got %0h expected %0h", k, bus.txd, exp_txd(eb, (k - 1) % FR + 1));
      end
    end
    tick();
    n_checks++; if (bus.tx_busy !== 1'b0) begin n_fail++; $display("FAIL parity_end_busy: got 1 expected 0"); end
  endtask
`endif

  initial begin
    bus.we      = 1'b0;
    bus.wdata   = 8'h00;
    bus.clr_ovf = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
